// File: rtl/cfa_pkg.sv
// Shared CFA definitions: Bayer pattern phases and per-sample colour codes.
package cfa_pkg;

  typedef enum logic [1:0] {
    CFA_RGGB = 2'd0,
    CFA_GRBG = 2'd1,
    CFA_GBRG = 2'd2,
    CFA_BGGR = 2'd3
  } cfa_pattern_e;

  typedef enum logic [1:0] {
    COL_R  = 2'd0,
    COL_GR = 2'd1,
    COL_GB = 2'd2,
    COL_B  = 2'd3
  } cfa_color_e;

endpackage

// File: rtl/cfa_color_select.sv
// Combinational Bayer classifier: picks the colour for a raster position and
// clips the matching signed channel to an unsigned CFA sample.
module cfa_color_select
  import cfa_pkg::*;
#(
  parameter int pixelBitWidth = 12
) (
  input  logic [1:0]               pattern,
  input  logic                     row_lsb,
  input  logic                     col_lsb,
  input  logic [pixelBitWidth:0]   in_r,
  input  logic [pixelBitWidth:0]   in_g,
  input  logic [pixelBitWidth:0]   in_b,
  output logic [pixelBitWidth-1:0] pixel,
  output logic [1:0]               color
);

  logic [1:0]             phase;
  logic [pixelBitWidth:0] sel;

  always_comb begin
    phase = pattern ^ {row_lsb, col_lsb};
    sel   = '0;
    unique case (cfa_color_e'(phase))
      COL_R:          sel = in_r;
      COL_GR, COL_GB: sel = in_g;
      COL_B:          sel = in_b;
      default:        sel = '0;
    endcase
    // Negative samples floor at zero; the positive range always fits.
    pixel = sel[pixelBitWidth] ? '0 : sel[pixelBitWidth-1:0];
    color = phase;
  end

endmodule

// File: rtl/cfa_mosaic_tx.sv
// Re-mosaicing transmitter: RGB pixel stream in, one Bayer CFA sample per
// pixel out, with raster tracking and a single registered output stage.
module cfa_mosaic_tx
  import cfa_pkg::*;
#(
  parameter int pixelBitWidth = 12,
  parameter int WIDTH         = 640,
  parameter int HEIGHT        = 480,
  parameter int PATTERN       = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [pixelBitWidth:0]   in_r,
  input  logic [pixelBitWidth:0]   in_g,
  input  logic [pixelBitWidth:0]   in_b,
  input  logic                     in_sof,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [pixelBitWidth-1:0] out_pixel,
  output logic [1:0]               out_color,
  output logic                     out_sof,
  output logic                     out_eol,
  output logic                     out_eof,
  output logic                     sof_err
);

  localparam int CW = $clog2(WIDTH);
  localparam int RW = $clog2(HEIGHT);
  localparam cfa_pattern_e PAT = cfa_pattern_e'(PATTERN[1:0]);

  logic [CW-1:0]            col, pos_col, nxt_col;
  logic [RW-1:0]            row, pos_row, nxt_row;
  logic                     accept;
  logic                     last_col, last_row, at_origin;
  logic [pixelBitWidth-1:0] sel_pixel;
  logic [1:0]               sel_color;

  always_comb begin
    in_ready  = !out_valid || out_ready;
    accept    = in_valid && in_ready;
    at_origin = (row == '0) && (col == '0);
    // in_sof forces the beat to (0,0) regardless of where the counters are.
    pos_row   = in_sof ? '0 : row;
    pos_col   = in_sof ? '0 : col;
    last_col  = (pos_col == CW'(WIDTH - 1));
    last_row  = (pos_row == RW'(HEIGHT - 1));
    nxt_col   = last_col ? '0 : pos_col + 1'b1;
    nxt_row   = pos_row;
    if (last_col) nxt_row = last_row ? '0 : pos_row + 1'b1;
  end

  cfa_color_select #(
    .pixelBitWidth(pixelBitWidth)
  ) u_color_select (
    .pattern (PAT),
    .row_lsb (pos_row[0]),
    .col_lsb (pos_col[0]),
    .in_r    (in_r),
    .in_g    (in_g),
    .in_b    (in_b),
    .pixel   (sel_pixel),
    .color   (sel_color)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      row       <= '0;
      col       <= '0;
      out_valid <= 1'b0;
      out_pixel <= '0;
      out_color <= '0;
      out_sof   <= 1'b0;
      out_eol   <= 1'b0;
      out_eof   <= 1'b0;
      sof_err   <= 1'b0;
    end else if (accept) begin
      row       <= nxt_row;
      col       <= nxt_col;
      out_valid <= 1'b1;
      out_pixel <= sel_pixel;
      out_color <= sel_color;
      out_sof   <= (pos_row == '0) && (pos_col == '0);
      out_eol   <= last_col;
      out_eof   <= last_col && last_row;
      if (in_sof && !at_origin) sof_err <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cfa_mosaic_tx.sv
// Directed bench for cfa_mosaic_tx on a 4x2 frame, RGGB and BGGR instances
// sharing one input stream.
module tb_cfa_mosaic_tx;
  localparam int PW = 12;
  localparam int W  = 4;
  localparam int H  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, in_valid, in_sof, out_ready;
  logic [PW:0]   in_r, in_g, in_b;

  logic          in_ready0, out_valid0, sof0, eol0, eof0, sof_err0;
  logic [PW-1:0] pix0;
  logic [1:0]    col0;
  logic          in_ready3, out_valid3, sof3, eol3, eof3, sof_err3;
  logic [PW-1:0] pix3;
  logic [1:0]    col3;

  cfa_mosaic_tx #(.pixelBitWidth(PW), .WIDTH(W), .HEIGHT(H), .PATTERN(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
    .in_r(in_r), .in_g(in_g), .in_b(in_b), .in_sof(in_sof),
    .out_valid(out_valid0), .out_ready(out_ready), .out_pixel(pix0),
    .out_color(col0), .out_sof(sof0), .out_eol(eol0), .out_eof(eof0),
    .sof_err(sof_err0)
  );

  cfa_mosaic_tx #(.pixelBitWidth(PW), .WIDTH(W), .HEIGHT(H), .PATTERN(3)) dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready3),
    .in_r(in_r), .in_g(in_g), .in_b(in_b), .in_sof(in_sof),
    .out_valid(out_valid3), .out_ready(out_ready), .out_pixel(pix3),
    .out_color(col3), .out_sof(sof3), .out_eol(eol3), .out_eof(eof3),
    .sof_err(sof_err3)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic send(input logic [PW:0] r, input logic [PW:0] g, input logic [PW:0] b,
                      input logic sof);
    in_valid = 1'b1;
    in_r = r; in_g = g; in_b = b;
    in_sof = sof;
    step();
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  int exp_pix1[8] = '{100, 200, 100, 200, 200, 300, 200, 300};
  int exp_col0[8] = '{0, 1, 0, 1, 2, 3, 2, 3};
  int exp_col3[8] = '{3, 2, 3, 2, 1, 0, 1, 0};

  function automatic int pick(input int c, input int r, input int g, input int b);
    return (c == 0) ? r : (c == 3) ? b : g;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_sof = 1'b0; out_ready = 1'b1;
    in_r = '0; in_g = '0; in_b = '0;

    // Reset state
    do_reset();
    check_eq("rst_out_valid", out_valid0, 0);
    check_eq("rst_in_ready", in_ready0, 1);
    check_eq("rst_sof_err", sof_err0, 0);
    check_eq("rst_out_pixel", pix0, 0);
    check_eq("rst_flags", {sof0, eol0, eof0, col0}, 0);

    // Streaming frame, RGGB
    for (int i = 0; i < 8; i++) begin
      send(13'd100, 13'd200, 13'd300, i == 0);
      check_eq($sformatf("t1_valid_%0d", i), out_valid0, 1);
      check_eq($sformatf("t1_pix_%0d", i), pix0, exp_pix1[i]);
      check_eq($sformatf("t1_col_%0d", i), col0, exp_col0[i]);
      check_eq($sformatf("t1_sof_%0d", i), sof0, i == 0);
      check_eq($sformatf("t1_eol_%0d", i), eol0, (i == 3) || (i == 7));
      check_eq($sformatf("t1_eof_%0d", i), eof0, i == 7);
    end
    step();
    check_eq("t1_drain_valid", out_valid0, 0);
    check_eq("t1_sof_err", sof_err0, 0);

    // Clip at (0,0), red site
    do_reset(); send(13'h1FFF, 13'd5, 13'd5, 1'b0); check_eq("clip_neg1", pix0, 0);
    do_reset(); send(13'h0FFF, 13'd5, 13'd5, 1'b0); check_eq("clip_max", pix0, 4095);
    do_reset(); send(13'h1000, 13'd5, 13'd5, 1'b0); check_eq("clip_minneg", pix0, 0);

    // Backpressure
    do_reset();
    send(13'd10, 13'd10, 13'd10, 1'b1);
    out_ready = 1'b0;
    in_valid = 1'b1; in_r = 13'd20; in_g = 13'd20; in_b = 13'd20; in_sof = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq($sformatf("bp_in_ready_%0d", i), in_ready0, 0);
      step();
      check_eq($sformatf("bp_hold_%0d", i), {out_valid0, sof0, col0, pix0}, {1'b1, 1'b1, 2'd0, 12'd10});
    end
    out_ready = 1'b1;
    #1;
    check_eq("bp_release_ready", in_ready0, 1);
    step();
    in_valid = 1'b0;
    check_eq("bp_next_beat", {out_valid0, sof0, col0, pix0}, {1'b1, 1'b0, 2'd1, 12'd20});
    step();
    check_eq("bp_pop_drop", out_valid0, 0);
    send(13'd30, 13'd30, 13'd30, 1'b0);
    check_eq("bp_no_dup", {col0, pix0}, {2'd0, 12'd30});

    // BGGR vs RGGB, distinct channels
    do_reset();
    for (int i = 0; i < 8; i++) begin
      send(13'(i * 10 + 1), 13'(i * 10 + 2), 13'(i * 10 + 3), i == 0);
      check_eq($sformatf("p3_col_%0d", i), col3, exp_col3[i]);
      check_eq($sformatf("p3_pix_%0d", i), pix3, pick(exp_col3[i], i * 10 + 1, i * 10 + 2, i * 10 + 3));
      check_eq($sformatf("p0_pix_%0d", i), pix0, pick(exp_col0[i], i * 10 + 1, i * 10 + 2, i * 10 + 3));
    end
    check_eq("p3_eof", eof3, 1);

    // Stray in_sof mid-frame
    do_reset();
    send(13'd1, 13'd2, 13'd3, 1'b1);
    send(13'd1, 13'd2, 13'd3, 1'b0);
    check_eq("sof_legal_no_err", sof_err0, 0);
    send(13'd7, 13'd8, 13'd9, 1'b1);
    check_eq("sof_err_set", sof_err0, 1);
    check_eq("sof_err_beat", {sof0, col0, pix0}, {1'b1, 2'd0, 12'd7});
    check_eq("sof_err_beat_p3", col3, 3);
    send(13'd7, 13'd8, 13'd9, 1'b0);
    check_eq("sof_resume", {sof0, col0, pix0}, {1'b0, 2'd1, 12'd8});
    step();
    check_eq("sof_err_sticky", sof_err0, 1);

    // Reset mid-line with a sample in flight
    out_ready = 1'b0;
    send(13'd4, 13'd5, 13'd6, 1'b0);
    check_eq("mid_valid_before", out_valid0, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    check_eq("mid_rst_valid", out_valid0, 0);
    check_eq("mid_rst_sof_err", sof_err0, 0);
    check_eq("mid_rst_in_ready", in_ready0, 1);
    send(13'd11, 13'd12, 13'd13, 1'b0);
    check_eq("mid_first_beat", {out_valid0, sof0, col0, pix0}, {1'b1, 1'b1, 2'd0, 12'd11});
    send(13'd11, 13'd12, 13'd13, 1'b0);
    check_eq("mid_second_beat", {sof0, col0, pix0}, {1'b0, 2'd1, 12'd12});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
